// File: rtl/param_proc.sv
// param_proc: parametrised multicycle processor (R7 = PC) with a req/ack memory
// handshake that tolerates wait states, plus a combinational debug register port.
module param_proc #(
  parameter int DW = 16,
  parameter int AW = 16
) (
  input  logic          Clock,
  input  logic          Resetn,
  input  logic          Run,
  output logic          Done,
  output logic          Busy,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ack,
  input  logic [2:0]    dbg_sel,
  output logic [DW-1:0] dbg_reg
);
  typedef enum logic [2:0] {IDLE, FETCH, EXEC, WB, IMM, MEM} state_t;
  localparam logic [2:0] OP_MV = 3'd0, OP_MVI = 3'd1, OP_ADD = 3'd2, OP_SUB = 3'd3;
  localparam logic [2:0] OP_LD = 3'd4, OP_ST = 3'd5, OP_MVNZ = 3'd6, OP_AND = 3'd7;
  state_t state_q, state_d;
  logic [DW-1:0] r_q [8];
  logic [DW-1:0] r_d [8];
  logic [DW-1:0] g_q, g_d;
  logic [8:0] ir_q, ir_d;
  logic done_q, done_d, retire;
  logic [2:0] op, rx, ry;
  logic [DW-1:0] vx, vy;
  assign op = ir_q[8:6];
  assign rx = ir_q[5:3];
  assign ry = ir_q[2:0];
  assign vx = r_q[rx];
  assign vy = r_q[ry];
  always_comb begin
    state_d = state_q;
    r_d = r_q;
    g_d = g_q;
    ir_d = ir_q;
    retire = 1'b0;
    case (state_q)
      IDLE: state_d = Run ? FETCH : IDLE;
      FETCH: if (mem_ack) begin
        ir_d = mem_rdata[DW-1:DW-9];
        r_d[7] = r_q[7] + DW'(1);
        state_d = EXEC;
      end
      EXEC: case (op)
        OP_MV: begin
          r_d[rx] = vy;
          retire = 1'b1;
        end
        OP_MVNZ: begin
          r_d[rx] = g_q != '0 ? vy : vx;
          retire = 1'b1;
        end
        OP_ADD: begin
          g_d = vx + vy;
          state_d = WB;
        end
        OP_SUB: begin
          g_d = vx - vy;
          state_d = WB;
        end
        OP_AND: begin
          g_d = vx & vy;
          state_d = WB;
        end
        OP_MVI: state_d = IMM;
        default: state_d = MEM;
      endcase
      WB: begin
        r_d[rx] = g_q;
        retire = 1'b1;
      end
      // immediate load into R7 overrides the PC increment
      IMM: if (mem_ack) begin
        r_d[7] = r_q[7] + DW'(1);
        r_d[rx] = mem_rdata;
        retire = 1'b1;
      end
      MEM: if (mem_ack) begin
        r_d[rx] = op == OP_LD ? mem_rdata : vx;
        retire = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    if (retire) state_d = Run ? FETCH : IDLE;
    done_d = retire;
  end
  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      state_q <= IDLE;
      r_q <= '{default: '0};
      g_q <= '0;
      ir_q <= '0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      r_q <= r_d;
      g_q <= g_d;
      ir_q <= ir_d;
      done_q <= done_d;
    end
  end
  // memory interface decoded from registered state only
  assign mem_req = state_q == FETCH || state_q == IMM || state_q == MEM;
  assign mem_we = state_q == MEM && op == OP_ST;
  assign mem_addr = state_q == MEM ? vy[AW-1:0] :
                    (state_q == FETCH || state_q == IMM) ? r_q[7][AW-1:0] : '0;
  assign mem_wdata = mem_we ? vx : '0;
  assign Busy = state_q != IDLE;
  assign Done = done_q;
  assign dbg_reg = r_q[dbg_sel];
endmodule

// File: tb/tb_param_proc.sv
`timescale 1ns/10ps
// tb_param_proc: table vectors, directed multi-cycle sequences and a randomized
// program run checked against an instruction-level model of the processor.
module tb_param_proc;
  localparam int MV = 0, MVI = 1, ADD = 2, SUB = 3, LD = 4, ST = 5, MVNZ = 6, ANDOP = 7;
  logic Clock = 1'b0, Resetn = 1'b0, Run = 1'b0, mem_ack = 1'b0;
  logic Done, Busy, mem_req, mem_we;
  logic [15:0] mem_addr, mem_wdata, dbg_reg;
  logic [15:0] mem_rdata = 16'h0;
  logic [2:0] dbg_sel = 3'd0;
  logic [15:0] mem [65536];
  logic [15:0] mm [65536];
  logic [15:0] mr [8];
  logic [15:0] mg;
  logic [15:0] pq [$];
  int errors = 0, checks = 0, cyc = 0, nwait = 0, wcnt = 0, rnd_need = 0;
  int wait_n = 0, slow_wait = 0, rand_wait = 0;
  logic [15:0] slow_addr = 16'hFFFF;

  param_proc #(.DW(16), .AW(16)) dut (
    .Clock(Clock), .Resetn(Resetn), .Run(Run), .Done(Done), .Busy(Busy),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .dbg_sel(dbg_sel), .dbg_reg(dbg_reg)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    int op, rx, ry;
    logic [15:0] a, b;
    int w;
    logic [15:0] exp;
    int lat;
  } vec_t;
  vec_t tv [9];

  function automatic logic [15:0] enc(int op, int rx, int ry);
    return {3'(op), 3'(rx), 3'(ry), 7'b0};
  endfunction

  function automatic logic [15:0] fill(int a);
    logic [31:0] h;
    h = 32'(a) * 32'h9E3779B1;
    return h[31:16];
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_reg(input string nm, input int i, input logic [15:0] exp);
    dbg_sel = 3'(i);
    #0.25;
    chk(nm, {16'h0, dbg_reg}, {16'h0, exp});
  endtask

  // memory responder lives in the single stimulus process: ack decided at negedge, write committed at posedge
  task automatic tick();
    logic s_req, s_ack, s_we;
    logic [15:0] s_addr, s_wdata;
    int need;
    @(negedge Clock);
    need = rand_wait != 0 ? rnd_need : (mem_addr == slow_addr ? slow_wait : wait_n);
    mem_ack = mem_req && wcnt >= need;
    mem_rdata = mem_ack ? mem[mem_addr] : 16'h0;
    s_req = mem_req; s_ack = mem_ack; s_we = mem_we; s_addr = mem_addr; s_wdata = mem_wdata;
    @(posedge Clock);
    cyc++;
    if (s_req && !s_ack) begin
      nwait++;
      wcnt++;
    end else begin
      wcnt = 0;
      rnd_need = int'($urandom_range(0, 2));
    end
    if (s_req && s_ack && s_we) mem[s_addr] = s_wdata;
    #1;
  endtask

  task automatic do_reset();
    Resetn = 1'b0;
    Run = 1'b0;
    tick();
    tick();
    Resetn = 1'b1;
  endtask

  task automatic wait_done(input string nm, output int lat, output int w);
    int c0, w0;
    bit got;
    c0 = cyc; w0 = nwait; got = 1'b0;
    for (int i = 0; i < 64 && !got; i++) begin
      tick();
      got = Done;
    end
    chk({nm, "_done"}, 32'(got), 32'd1);
    lat = cyc - c0;
    w = nwait - w0;
  endtask

  task automatic load_pq();
    foreach (pq[i]) mem[i] = pq[i];
  endtask

  task automatic mem_init();
    for (int a = 0; a < 65536; a++) mem[a] = fill(a);
  endtask

  // architectural model: one whole instruction per call, memory and registers as plain arrays
  task automatic model_exec(output int base);
    logic [15:0] ir;
    int op, rx, ry;
    ir = mm[mr[7]];
    mr[7] = mr[7] + 16'd1;
    op = int'(ir[15:13]); rx = int'(ir[12:10]); ry = int'(ir[9:7]);
    base = (op == MV || op == MVNZ) ? 2 : 3;
    case (op)
      MV: mr[rx] = mr[ry];
      MVI: begin
        ir = mm[mr[7]];
        mr[7] = mr[7] + 16'd1;
        mr[rx] = ir;
      end
      ADD: begin mg = mr[rx] + mr[ry]; mr[rx] = mg; end
      SUB: begin mg = mr[rx] - mr[ry]; mr[rx] = mg; end
      ANDOP: begin mg = mr[rx] & mr[ry]; mr[rx] = mg; end
      LD: mr[rx] = mm[mr[ry]];
      ST: mm[mr[ry]] = mr[rx];
      default: if (mg != 16'h0) mr[rx] = mr[ry];
    endcase
  endtask

  initial begin
    int lat, w, base, nreq, bad;
    bit got;
    tv[0] = '{ADD,   0, 1, 16'h0005, 16'h0003, 0, 16'h0008, 3};
    tv[1] = '{SUB,   0, 1, 16'h0002, 16'h0003, 0, 16'hFFFF, 3};
    tv[2] = '{ANDOP, 0, 1, 16'h00FF, 16'h0F0F, 0, 16'h000F, 3};
    tv[3] = '{MV,    2, 3, 16'h0001, 16'h1234, 0, 16'h1234, 2};
    tv[4] = '{ADD,   4, 6, 16'hFFFF, 16'h0002, 1, 16'h0001, 4};
    tv[5] = '{SUB,   5, 4, 16'h8000, 16'h0001, 2, 16'h7FFF, 5};
    tv[6] = '{ANDOP, 3, 2, 16'h0000, 16'hFFFF, 0, 16'h0000, 3};
    tv[7] = '{MVNZ,  5, 1, 16'h00AA, 16'h0055, 0, 16'h00AA, 2};
    tv[8] = '{MV,    1, 0, 16'h0007, 16'h0009, 3, 16'h0009, 5};
    mem_init();

    // T1: reset state and basic program
    pq = '{enc(MVI,0,0), 16'd5, enc(MVI,1,0), 16'd3, enc(ADD,0,1)};
    load_pq();
    do_reset();
    chk("rst_done", 32'(Done), 0);
    chk("rst_busy", 32'(Busy), 0);
    chk("rst_req", 32'(mem_req), 0);
    chk("rst_we", 32'(mem_we), 0);
    chk("rst_addr", 32'(mem_addr), 0);
    for (int r = 0; r < 8; r++) chk_reg($sformatf("rst_r%0d", r), r, 16'h0);
    Run = 1'b1;
    wait_done("t1_mvi0", lat, w);
    wait_done("t1_mvi1", lat, w);
    chk("t1_mvi_lat", lat, 3);
    wait_done("t1_add", lat, w);
    chk("t1_add_lat", lat, 3);
    chk_reg("t1_r0", 0, 16'd8);
    chk_reg("t1_r1", 1, 16'd3);
    chk_reg("t1_r7", 7, 16'd5);
    Run = 1'b0;
    tick();
    chk("t1_done_pulse", 32'(Done), 0);

    // table vectors: preload two registers with mvi, then the instruction under test
    for (int k = 0; k < 9; k++) begin
      wait_n = tv[k].w;
      pq = '{enc(MVI,tv[k].rx,0), tv[k].a, enc(MVI,tv[k].ry,0), tv[k].b, enc(tv[k].op,tv[k].rx,tv[k].ry)};
      load_pq();
      do_reset();
      Run = 1'b1;
      repeat (3) wait_done($sformatf("vec%0d", k), lat, w);
      chk_reg($sformatf("vec%0d_rx", k), tv[k].rx, tv[k].exp);
      chk($sformatf("vec%0d_lat", k), lat, tv[k].lat);
      Run = 1'b0;
    end
    wait_n = 0;

    // T2: sub wraps, and, then mvnz confirms G nonzero
    pq = '{enc(MVI,0,0), 16'd2, enc(MVI,1,0), 16'd3, enc(SUB,0,1), enc(ANDOP,0,1), enc(MVNZ,6,0)};
    load_pq();
    do_reset();
    Run = 1'b1;
    repeat (3) wait_done("t2_sub", lat, w);
    chk_reg("t2_sub_r0", 0, 16'hFFFF);
    wait_done("t2_and", lat, w);
    chk_reg("t2_and_r0", 0, 16'h0003);
    wait_done("t2_mvnz", lat, w);
    chk_reg("t2_g_r6", 6, 16'h0003);
    Run = 1'b0;

    // T3: store with three wait states, then load back
    pq = '{enc(MVI,2,0), 16'h0040, enc(MVI,3,0), 16'hBEEF, enc(ST,3,2), enc(LD,4,2)};
    load_pq();
    slow_addr = 16'h0040; slow_wait = 3;
    do_reset();
    Run = 1'b1;
    repeat (2) wait_done("t3_mvi", lat, w);
    nreq = 0; bad = 0; got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      tick();
      if (mem_req && mem_we) begin
        nreq++;
        if (mem_addr != 16'h0040 || mem_wdata != 16'hBEEF) bad++;
      end
      got = Done;
    end
    chk("t3_st_done", 32'(got), 1);
    chk("t3_st_req_cycles", nreq, 4);
    chk("t3_st_stable", bad, 0);
    chk("t3_wdata_idle", 32'(mem_wdata), 0);
    wait_done("t3_ld", lat, w);
    chk("t3_ld_lat", lat, 6);
    chk_reg("t3_r4", 4, 16'hBEEF);
    Run = 1'b0;
    slow_addr = 16'hFFFF; slow_wait = 0;

    // T4: mvnz with G = 0, then with G = 1
    pq = '{enc(MVI,5,0), 16'h0077, enc(MVI,1,0), 16'h0012, enc(MVNZ,5,1),
           enc(MVI,6,0), 16'h0001, enc(MVI,0,0), 16'h0000, enc(ADD,0,6), enc(MVNZ,5,1)};
    load_pq();
    do_reset();
    Run = 1'b1;
    repeat (3) wait_done("t4_mvnz0", lat, w);
    chk("t4_mvnz0_lat", lat, 2);
    chk_reg("t4_r5_kept", 5, 16'h0077);
    repeat (4) wait_done("t4_mvnz1", lat, w);
    chk_reg("t4_r5_moved", 5, 16'h0012);
    Run = 1'b0;

    // T5: jumps through R7
    mem[0] = enc(MVI,7,0); mem[1] = 16'h0010; mem[16'h0010] = enc(MV,7,0);
    do_reset();
    Run = 1'b1;
    wait_done("t5_mvi", lat, w);
    chk("t5_fetch_req", 32'(mem_req), 1);
    chk("t5_fetch_addr", 32'(mem_addr), 32'h10);
    chk_reg("t5_r7", 7, 16'h0010);
    wait_done("t5_mv", lat, w);
    chk("t5_mv_lat", lat, 2);
    chk("t5_fetch0_addr", 32'(mem_addr), 0);
    chk_reg("t5_r7_zero", 7, 16'h0000);
    Run = 1'b0;

    // T6a: Run dropped during a load wait state
    pq = '{enc(MVI,2,0), 16'h0040, enc(LD,4,2)};
    load_pq();
    mem[16'h0040] = 16'h1357;
    slow_addr = 16'h0040; slow_wait = 3;
    do_reset();
    Run = 1'b1;
    wait_done("t6_mvi", lat, w);
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      tick();
      got = mem_req && mem_addr == 16'h0040;
    end
    chk("t6_ld_wait_seen", 32'(got), 1);
    Run = 1'b0;
    wait_done("t6_ld", lat, w);
    chk("t6_busy_done", 32'(Busy), 0);
    chk("t6_req_done", 32'(mem_req), 0);
    chk_reg("t6_r4", 4, 16'h1357);
    tick();
    chk("t6_busy_idle", 32'(Busy), 0);
    chk("t6_done_low", 32'(Done), 0);

    // T6b: reset during a fetch wait abandons the request
    pq = '{enc(MVI,3,0), 16'h0055};
    load_pq();
    slow_addr = 16'h0002; slow_wait = 5;
    do_reset();
    Run = 1'b1;
    wait_done("t6b_mvi", lat, w);
    tick();
    tick();
    chk("t6b_req_pending", 32'(mem_req), 1);
    Resetn = 1'b0;
    Run = 1'b0;
    tick();
    chk("t6b_req_cleared", 32'(mem_req), 0);
    chk("t6b_busy", 32'(Busy), 0);
    for (int r = 0; r < 8; r++) chk_reg($sformatf("t6b_r%0d", r), r, 16'h0);
    Resetn = 1'b1;
    slow_addr = 16'hFFFF; slow_wait = 0;

    // randomized program with random wait states against the model
    mem_init();
    for (int a = 0; a < 65536; a++) mm[a] = fill(a);
    for (int a = 0; a < 512; a++) begin
      mem[a] = 16'($urandom);
      mm[a] = mem[a];
    end
    for (int r = 0; r < 8; r++) mr[r] = 16'h0;
    mg = 16'h0;
    rand_wait = 1;
    do_reset();
    Run = 1'b1;
    for (int n = 0; n < 300; n++) begin
      wait_done($sformatf("rnd%0d", n), lat, w);
      model_exec(base);
      if (n > 0) chk($sformatf("rnd%0d_lat", n), lat, base + w);
      for (int r = 0; r < 8; r++) chk_reg($sformatf("rnd%0d_r%0d", n, r), r, mr[r]);
    end
    Run = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
